sio_fifo_bridge: RTL

//  Buffered front end for the simple serial I/O core. Sits between the CPU-side bus decoder and the SIO's ce/rd/wr/cd port.
//  - TX: CPU pushes bytes into a TX FIFO; an FSM polls SIO status and writes each byte when the transmitter is free.
//  - RX: the FSM drains received bytes into an RX FIFO the CPU pops at leisure.
//  - Removes CPU polling of per-byte status.

---
 rtl/sio_fifo_bridge_if.sv | 32 +++
 rtl/sio_fifo_bridge.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sio_fifo_bridge_if.sv
// CPU-side FIFO port and SIO ce/rd/wr/cd port of the SIO FIFO bridge.
// master = CPU plus SIO core, slave = the bridge.
interface sio_fifo_bridge_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  tx_push;
    logic [7:0]            tx_data;
    logic                  tx_full;
    logic [DEPTH_LOG2:0]   tx_count;
    logic                  rx_pop;
    logic [7:0]            rx_data;
    logic                  rx_empty;
    logic [DEPTH_LOG2:0]   rx_count;
    logic                  sio_ce;
    logic                  sio_rd;
    logic                  sio_wr;
    logic                  sio_cd;
    logic [7:0]            sio_wdata;
    logic [7:0]            sio_rdata;

    modport master (
        output tx_push, tx_data, rx_pop, sio_rdata,
        input  tx_full, tx_count, rx_data, rx_empty, rx_count,
               sio_ce, sio_rd, sio_wr, sio_cd, sio_wdata
    );

    modport slave (
        input  tx_push, tx_data, rx_pop, sio_rdata,
        output tx_full, tx_count, rx_data, rx_empty, rx_count,
               sio_ce, sio_rd, sio_wr, sio_cd, sio_wdata
    );
endinterface

// File: rtl/sio_fifo_bridge.sv
// Generic circular FIFO with first-word-fall-through head, 0 when empty.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push dropped while full, pop ignored while empty.
module sio_fifo #(
    parameter int W          = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                push,
    input  logic [W-1:0]        push_dat,
    input  logic                pop,
    output logic [W-1:0]        pop_dat,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Buffered CPU front end for the SIO core: status-polling FSM moves bytes between FIFOs and SIO.
// Latency: status polled at most every 3 cycles; pushed byte reaches the SIO no sooner than 3 cycles later.
// Backpressure: tx_full to the CPU; while RX is full the byte is left waiting inside the SIO.
module sio_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    sio_fifo_bridge_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STAT  = 3'd1,
        EVAL  = 3'd2,
        RXRD  = 3'd3,
        RXCAP = 3'd4,
        TXWR  = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;
    logic       tx_pop;
    logic       rx_push;
    logic       rx_full;
    logic       rx_empty;
    logic       sio_ce_nx, sio_rd_nx, sio_wr_nx, sio_cd_nx;
    logic [7:0] sio_wdata_nx;
    logic       sio_ce_q, sio_rd_q, sio_wr_q, sio_cd_q;
    logic [7:0] sio_wdata_q;

    sio_fifo #(.W(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (bus.tx_push),
        .push_dat (bus.tx_data),
        .pop      (tx_pop),
        .pop_dat  (tx_head),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (bus.tx_count)
    );

    sio_fifo #(.W(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (rx_push),
        .push_dat (bus.sio_rdata),
        .pop      (bus.rx_pop),
        .pop_dat  (bus.rx_data),
        .full     (rx_full),
        .empty    (rx_empty),
        .count    (bus.rx_count)
    );

    assign bus.tx_full  = tx_full;
    assign bus.rx_empty = rx_empty;
    assign tx_pop       = (state == TXWR);
    assign rx_push      = (state == RXCAP);

    always_ff @(posedge clk) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    // sio_rdata in EVAL is the status byte the SIO registered during STAT.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = STAT;
            STAT:  state_nx = EVAL;
            EVAL: begin
                if (bus.sio_rdata[1] && !rx_full)       state_nx = RXRD;
                else if (bus.sio_rdata[0] && !tx_empty) state_nx = TXWR;
                else                                    state_nx = IDLE;
            end
            RXRD:  state_nx = RXCAP;
            RXCAP: state_nx = IDLE;
            TXWR:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave a flop aligned with their state.
    always_comb begin
        sio_ce_nx    = (state_nx == STAT) || (state_nx == RXRD) || (state_nx == TXWR);
        sio_rd_nx    = (state_nx == STAT) || (state_nx == RXRD);
        sio_wr_nx    = (state_nx == TXWR);
        sio_cd_nx    = (state_nx == STAT);
        sio_wdata_nx = (state_nx == TXWR) ? tx_head : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sio_ce_q    <= 1'b0;
            sio_rd_q    <= 1'b0;
            sio_wr_q    <= 1'b0;
            sio_cd_q    <= 1'b0;
            sio_wdata_q <= 8'h00;
        end else begin
            sio_ce_q    <= sio_ce_nx;
            sio_rd_q    <= sio_rd_nx;
            sio_wr_q    <= sio_wr_nx;
            sio_cd_q    <= sio_cd_nx;
            sio_wdata_q <= sio_wdata_nx;
        end
    end

    assign bus.sio_ce    = sio_ce_q;
    assign bus.sio_rd    = sio_rd_q;
    assign bus.sio_wr    = sio_wr_q;
    assign bus.sio_cd    = sio_cd_q;
    assign bus.sio_wdata = sio_wdata_q;
endmodule
